response_router: RTL and testbench
==================================

RESPONSE_ROUTER -- requirements
Module: response_router

Interface
REQ-001 SHALL have parameter PORTCOUNT, default 4, the number of requesting ports served by the upstream round-robin arbiter.
REQ-002 SHALL have parameter PORTADDRWIDTH, default 2, the width of a port index.
REQ-003 SHALL have parameter DATAWIDTH, default 16, the response payload width.
REQ-004 SHALL have parameter DEPTH, default 4, the maximum number of outstanding requests; it SHALL be a power of two.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port async_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port clk_en, input, 1 bit: global clock enable.
REQ-008 SHALL have port IssueValid, input, 1 bit: a request was granted and issued to the shared resource.
REQ-009 SHALL have port IssuePort, input, PORTADDRWIDTH bits: index of the granted port (the arbiter's PortSelection).
REQ-010 SHALL have port IssueReady, output, 1 bit: the tag FIFO can accept an issue.
REQ-011 SHALL have port RespValid, input, 1 bit: the shared resource presents a response.
REQ-012 SHALL have port RespData, input, DATAWIDTH bits: the response payload.
REQ-013 SHALL have port RespReady, output, 1 bit: the response is accepted this cycle.
REQ-014 SHALL have port PortRespValid, output, PORTCOUNT bits: one-hot valid toward the ports.
REQ-015 SHALL have port PortRespData, output, DATAWIDTH bits: payload shared by all ports.
REQ-016 SHALL have port PortRespReady, input, PORTCOUNT bits: per-port accept.
REQ-017 SHALL have port Outstanding, output, PORTADDRWIDTH+1 bits, sized so that it can hold the value DEPTH: count of tags currently in the FIFO.
REQ-018 SHALL have port RouteError, output, 1 bit: sticky error flag.

Function
REQ-019 SHALL hold the issue-order port indices in a DEPTH-entry in-order tag FIFO; responses return in issue order.
REQ-020 SHALL push IssuePort when clk_en && IssueValid && IssueReady && IssuePort < PORTCOUNT.
REQ-021 SHALL drive IssueReady = clk_en && !full; full pushes SHALL NOT bypass a same-cycle pop.
REQ-022 SHALL reject, rather than push, an issue with IssuePort >= PORTCOUNT, and SHALL set RouteError.
REQ-023 SHALL use a one-entry output holding register with states EMPTY and HOLD.
REQ-024 SHALL drive RespReady = clk_en && FIFO non-empty && (state EMPTY || selected PortRespReady bit high).
REQ-025 On a response accept, SHALL latch RespData and the head tag, pop the FIFO, and enter HOLD; latency is one cycle from accept to PortRespValid.
REQ-026 In HOLD, SHALL drive PortRespValid with only the bit at the latched tag set, and all other bits zero.
REQ-027 In HOLD, when the tagged PortRespReady is high, SHALL return to EMPTY, or stay in HOLD with new data if a response is accepted in the same cycle (back-to-back, one per cycle).
REQ-028 SHALL ignore PortRespReady bits other than the tagged one.
REQ-029 SHALL keep RespReady low when the FIFO is empty, so a push issued in the same cycle is not usable until the next cycle.
REQ-030 SHALL set RouteError when RespValid is high, clk_en is high and the FIFO is empty; that response is not accepted.
REQ-031 SHALL update Outstanding by +1 on a push, -1 on a pop, and leave it unchanged when both occur in the same cycle.
REQ-032 SHALL keep read/write pointers PORTADDRWIDTH-independent, log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-033 When clk_en is low, SHALL freeze all state and force IssueReady and RespReady to 0; PortRespValid SHALL still reflect the held state.

Reset
REQ-034 Asynchronous assertion of async_rst SHALL immediately clear the FIFO pointers, Outstanding, the state (to EMPTY), RouteError and PortRespValid.
REQ-035 Reset mid-transfer SHALL discard all outstanding tags and held data; PortRespData SHALL reset to 0.
REQ-036 RouteError SHALL clear only on reset.

Structure
REQ-037 A shared package SHALL hold the state enum (EMPTY, HOLD) and the default width constants.
REQ-038 The tag FIFO SHALL be one sub-module, tag_fifo, parameterized by width and DEPTH.

Verification
REQ-039 Issue ports 2,0,3; then 3 responses 0xA1,0xB2,0xC3 with all ready -> PortRespValid 0100/0001/1000 carrying A1/B2/C3, one per cycle after a 1-cycle latency.
REQ-040 Issue 4 with no response -> IssueReady=0 and Outstanding=4; a 5th issue is dropped; after 1 response, Outstanding=3 and IssueReady=1.
REQ-041 HOLD on port 1 with PortRespReady=1101 for 3 cycles -> PortRespValid stays 0010, RespReady=0; raise bit 1 -> a transfer completes.
REQ-042 RespValid with Outstanding=0 -> RespReady=0 and RouteError=1, held until reset; an issue with IssuePort=5 at PORTCOUNT=5/width 3 -> RouteError=1 and no push.
REQ-043 Assert async_rst between clock edges while in HOLD with 3 outstanding -> PortRespValid=0 and Outstanding=0 before the next edge.
REQ-044 clk_en=0 with RespValid and IssueValid high -> no state change and both ready outputs 0.

Source files
------------

// File: rtl/response_router_pkg.sv
// response_router_pkg: output-register state encoding and default sizing shared by the response router files.
package response_router_pkg;
    localparam int DEF_PORTCOUNT     = 4;
    localparam int DEF_PORTADDRWIDTH = 2;
    localparam int DEF_DATAWIDTH     = 16;
    localparam int DEF_DEPTH         = 4;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;
    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of port tags; pointers wrap modulo DEPTH, count tracks occupancy.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   async_rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    always_comb begin
        mem_d = mem_q;
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
        if (push)
            mem_d[wr_q] = push_data;
    end
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign head  = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    assign count = cnt_q;
endmodule

// File: rtl/response_router.sv
// response_router: returns in-order responses from a shared resource to the port that issued each request,
// through a tag FIFO and a one-entry output holding register.
module response_router
    import response_router_pkg::*;
#(
    parameter int PORTCOUNT     = DEF_PORTCOUNT,
    parameter int PORTADDRWIDTH = DEF_PORTADDRWIDTH,
    parameter int DATAWIDTH     = DEF_DATAWIDTH,
    parameter int DEPTH         = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     async_rst,
    input  logic                     clk_en,
    input  logic                     IssueValid,
    input  logic [PORTADDRWIDTH-1:0] IssuePort,
    output logic                     IssueReady,
    input  logic                     RespValid,
    input  logic [DATAWIDTH-1:0]     RespData,
    output logic                     RespReady,
    output logic [PORTCOUNT-1:0]     PortRespValid,
    output logic [DATAWIDTH-1:0]     PortRespData,
    input  logic [PORTCOUNT-1:0]     PortRespReady,
    output logic [PORTADDRWIDTH:0]   Outstanding,
    output logic                     RouteError
);
    logic [0:0]               state_q, state_d;
    logic [PORTADDRWIDTH-1:0] tag_q, tag_d;
    logic [DATAWIDTH-1:0]     data_q, data_d;
    logic                     err_q, err_d;
    logic                     port_ok, push, accept, tagged_ready;
    logic                     fifo_empty, fifo_full;
    logic [PORTADDRWIDTH-1:0] fifo_head;
    logic [$clog2(DEPTH):0]   fifo_count;
    assign port_ok      = 32'(IssuePort) < 32'(PORTCOUNT);
    assign tagged_ready = PortRespReady[tag_q];
    assign IssueReady   = clk_en && !fifo_full;
    assign RespReady    = clk_en && !fifo_empty && (state_q == EMPTY || tagged_ready);
    assign push         = IssueValid && IssueReady && port_ok;
    assign accept       = RespValid && RespReady;
    always_comb begin
        state_d = accept ? HOLD : (state_q == HOLD && clk_en && tagged_ready) ? EMPTY : state_q;
        tag_d   = accept ? fifo_head : tag_q;
        data_d  = accept ? RespData : data_q;
        err_d   = err_q || (clk_en && IssueValid && !port_ok) || (clk_en && RespValid && fifo_empty);
    end
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= EMPTY;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    tag_fifo #(.WIDTH(PORTADDRWIDTH), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .async_rst (async_rst),
        .push      (push),
        .push_data (IssuePort),
        .pop       (accept),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );
    assign PortRespValid = (state_q == HOLD) ? PORTCOUNT'(onehot(32'(tag_q))) : '0;
    assign PortRespData  = data_q;
    assign Outstanding   = (PORTADDRWIDTH+1)'(fifo_count);
    assign RouteError    = err_q;
endmodule

// File: tb/tb_response_router.sv
// tb_response_router: table-driven vectors plus hand sequences, checked against a tag-queue model and a response scoreboard.
module tb_response_router;
    localparam int PC = 4, AW = 2, DW = 16, DEPTH = 4;
    logic clk = 1'b0;
    logic rst, en, iv, rv;
    logic [AW-1:0] ip;
    logic [DW-1:0] rd;
    logic [PC-1:0] prr;
    logic ir, rr, err;
    logic [PC-1:0] prv;
    logic [DW-1:0] pdata;
    logic [AW:0] outst;
    logic en5, iv5, rv5, ir5, rr5, err5;
    logic [2:0] ip5;
    logic [DW-1:0] rd5, pdata5;
    logic [4:0] prr5, prv5;
    logic [3:0] outst5;
    always #5 clk = ~clk;
    response_router dut (
        .clk(clk), .async_rst(rst), .clk_en(en), .IssueValid(iv), .IssuePort(ip), .IssueReady(ir),
        .RespValid(rv), .RespData(rd), .RespReady(rr), .PortRespValid(prv), .PortRespData(pdata),
        .PortRespReady(prr), .Outstanding(outst), .RouteError(err)
    );
    response_router #(.PORTCOUNT(5), .PORTADDRWIDTH(3)) dut5 (
        .clk(clk), .async_rst(rst), .clk_en(en5), .IssueValid(iv5), .IssuePort(ip5), .IssueReady(ir5),
        .RespValid(rv5), .RespData(rd5), .RespReady(rr5), .PortRespValid(prv5), .PortRespData(pdata5),
        .PortRespReady(prr5), .Outstanding(outst5), .RouteError(err5)
    );
    typedef struct {
        logic [AW-1:0] port;
        logic [DW-1:0] data;
    } sb_t;
    typedef struct {
        logic          iv;
        logic [AW-1:0] ip;
        logic          rv;
        logic [DW-1:0] rd;
        logic [PC-1:0] prr;
        logic [PC-1:0] e_prv;
        logic [DW-1:0] e_data;
        logic [AW:0]   e_out;
    } vec_t;
    int n_cmp = 0, n_bad = 0;
    logic [AW-1:0] mq[$];
    sb_t sb[$];
    logic m_hold = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_tag = '0;
    vec_t tbl[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic step(input string nm);
        logic exp_ir, exp_rr, xfer, acc;
        logic [PC-1:0] exp_prv;
        sb_t e;
        #1;
        exp_ir  = en && mq.size() < DEPTH;
        exp_rr  = en && mq.size() != 0 && (!m_hold || prr[m_tag]);
        exp_prv = m_hold ? PC'(1) << m_tag : '0;
        chk({nm, ":issue_ready"}, 32'(ir), 32'(exp_ir));
        chk({nm, ":resp_ready"}, 32'(rr), 32'(exp_rr));
        chk({nm, ":port_valid"}, 32'(prv), 32'(exp_prv));
        chk({nm, ":outstanding"}, 32'(outst), 32'(mq.size()));
        chk({nm, ":route_error"}, 32'(err), 32'(m_err));
        xfer = en && m_hold && prr[m_tag];
        if (xfer) begin
            e = sb.pop_front();
            chk({nm, ":sb_valid"}, 32'(prv), 32'(PC'(1) << e.port));
            chk({nm, ":sb_data"}, 32'(pdata), 32'(e.data));
        end
        if (en && rv && mq.size() == 0)
            m_err = 1'b1;
        acc = exp_rr && rv;
        if (acc) begin
            e.port = mq.pop_front();
            e.data = rd;
            sb.push_back(e);
            m_tag  = e.port;
            m_hold = 1'b1;
        end else if (xfer)
            m_hold = 1'b0;
        if (exp_ir && iv)
            mq.push_back(ip);
        @(negedge clk);
    endtask
    task automatic put(input string nm, input logic v_iv, input logic [AW-1:0] v_ip, input logic v_rv,
                       input logic [DW-1:0] v_rd, input logic [PC-1:0] v_prr, input logic v_en);
        iv = v_iv; ip = v_ip; rv = v_rv; rd = v_rd; prr = v_prr; en = v_en;
        step(nm);
    endtask
    task automatic idle(input string nm);
        put(nm, 1'b0, '0, 1'b0, '0, 4'hF, 1'b1);
    endtask
    task automatic do_reset();
        iv = 0; rv = 0; ip = '0; rd = '0; prr = '0; en = 1'b1;
        rst = 1'b1;
        mq.delete(); sb.delete(); m_hold = 1'b0; m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
    initial begin
        en5 = 1'b1; iv5 = 1'b0; ip5 = '0; rv5 = 1'b0; rd5 = '0; prr5 = '0;
        rst = 1'b1; iv = 0; rv = 0; ip = '0; rd = '0; prr = '0; en = 1'b1;
        tbl[0] = '{1'b1, 2'd2, 1'b0, 16'h00, 4'hF, 4'b0000, 16'h00, 3'd0};
        tbl[1] = '{1'b1, 2'd0, 1'b0, 16'h00, 4'hF, 4'b0000, 16'h00, 3'd1};
        tbl[2] = '{1'b1, 2'd3, 1'b0, 16'h00, 4'hF, 4'b0000, 16'h00, 3'd2};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 16'hA1, 4'hF, 4'b0000, 16'h00, 3'd3};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 16'hB2, 4'hF, 4'b0100, 16'hA1, 3'd2};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 16'hC3, 4'hF, 4'b0001, 16'hB2, 3'd1};
        tbl[6] = '{1'b0, 2'd0, 1'b0, 16'h00, 4'hF, 4'b1000, 16'hC3, 3'd0};
        tbl[7] = '{1'b0, 2'd0, 1'b0, 16'h00, 4'hF, 4'b0000, 16'hC3, 3'd0};
        @(negedge clk);
        do_reset();
        #1;
        chk("reset_data", 32'(pdata), 32'h0);
        idle("reset");
        for (int i = 0; i < 8; i++) begin
            iv = tbl[i].iv; ip = tbl[i].ip; rv = tbl[i].rv; rd = tbl[i].rd; prr = tbl[i].prr; en = 1'b1;
            #1;
            chk($sformatf("vec%0d:prv", i), 32'(prv), 32'(tbl[i].e_prv));
            chk($sformatf("vec%0d:data", i), 32'(pdata), 32'(tbl[i].e_data));
            chk($sformatf("vec%0d:out", i), 32'(outst), 32'(tbl[i].e_out));
            step($sformatf("vec%0d", i));
        end
        for (int i = 0; i < 4; i++)
            put("fill", 1'b1, AW'(i), 1'b0, '0, 4'hF, 1'b1);
        put("fifth", 1'b1, 2'd0, 1'b0, '0, 4'hF, 1'b1);
        #1;
        chk("full:out", 32'(outst), 32'd4);
        chk("full:issue_ready", 32'(ir), 32'd0);
        put("full_resp", 1'b0, '0, 1'b1, 16'h55, 4'hF, 1'b1);
        #1;
        chk("after_pop:out", 32'(outst), 32'd3);
        chk("after_pop:issue_ready", 32'(ir), 32'd1);
        for (int i = 0; i < 3; i++)
            put("drain", 1'b0, '0, 1'b1, DW'(16'h60 + i), 4'hF, 1'b1);
        idle("drain_end");
        put("h_iss1", 1'b1, 2'd1, 1'b0, '0, 4'h0, 1'b1);
        put("h_iss2", 1'b1, 2'd2, 1'b0, '0, 4'h0, 1'b1);
        put("h_acc", 1'b0, '0, 1'b1, 16'h77, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            prr = 4'b1101; rv = 1'b1; rd = 16'h88;
            #1;
            chk("hold:prv", 32'(prv), 32'b0010);
            chk("hold:resp_ready", 32'(rr), 32'd0);
            step("hold");
        end
        put("h_release", 1'b0, '0, 1'b1, 16'h88, 4'b0010, 1'b1);
        put("h_last", 1'b0, '0, 1'b0, '0, 4'b0100, 1'b1);
        idle("h_end");
        for (int i = 0; i < 4; i++)
            put("r_fill", 1'b1, AW'(3 - i), 1'b0, '0, 4'h0, 1'b1);
        put("r_acc", 1'b0, '0, 1'b1, 16'h99, 4'h0, 1'b1);
        iv = 0; rv = 0; prr = '0;
        #1;
        chk("pre_rst:out", 32'(outst), 32'd3);
        chk("pre_rst:prv", 32'(prv), 32'b1000);
        #1 rst = 1'b1;
        #1;
        chk("async_rst:prv", 32'(prv), 32'd0);
        chk("async_rst:out", 32'(outst), 32'd0);
        chk("async_rst:data", 32'(pdata), 32'd0);
        mq.delete(); sb.delete(); m_hold = 1'b0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle("post_rst");
        put("e_iss1", 1'b1, 2'd3, 1'b0, '0, 4'h0, 1'b1);
        put("e_iss2", 1'b1, 2'd2, 1'b0, '0, 4'h0, 1'b1);
        put("e_acc", 1'b0, '0, 1'b1, 16'hAB, 4'h0, 1'b1);
        for (int i = 0; i < 2; i++)
            put("en_low", 1'b1, 2'd1, 1'b1, 16'hCD, 4'h0, 1'b0);
        put("en_back", 1'b0, '0, 1'b1, 16'hEF, 4'b1000, 1'b1);
        put("en_last", 1'b0, '0, 1'b0, '0, 4'b0100, 1'b1);
        put("orphan", 1'b0, '0, 1'b1, 16'h11, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++)
            idle("sticky");
        #1;
        chk("sticky:route_error", 32'(err), 32'd1);
        do_reset();
        idle("err_cleared");
        #1;
        chk("dut5:err_init", 32'(err5), 32'd0);
        iv5 = 1'b1; ip5 = 3'd5;
        @(negedge clk);
        iv5 = 1'b0;
        #1;
        chk("dut5:err_bad_port", 32'(err5), 32'd1);
        chk("dut5:no_push", 32'(outst5), 32'd0);
        iv5 = 1'b1; ip5 = 3'd4;
        @(negedge clk);
        iv5 = 1'b0;
        #1;
        chk("dut5:push_port4", 32'(outst5), 32'd1);
        chk("dut5:prv_idle", 32'(prv5), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
